// File: rtl/mult_issue_queue_pkg.sv
// Shared types for the multiplier issue queue: issue word, CDB bundle and queue entry layout.
package mult_issue_queue_pkg;

  localparam int IQ_TAG_W  = 6;
  localparam int IQ_DATA_W = 32;

  typedef struct packed {
    logic [IQ_TAG_W-1:0]  rd_tag;
    logic [IQ_DATA_W-1:0] rs1_data;
    logic [IQ_DATA_W-1:0] rs2_data;
  } common_fifo_data;

  typedef struct packed {
    logic                 valid;
    logic [IQ_TAG_W-1:0]  tag;
    logic [IQ_DATA_W-1:0] result;
  } cdb_bfm;

  typedef struct packed {
    logic [IQ_DATA_W-1:0] data;
    logic [IQ_TAG_W-1:0]  tag;
    logic                 valid;
  } iq_src_t;

  typedef struct packed {
    logic                valid;
    logic [IQ_TAG_W-1:0] rd_tag;
    iq_src_t             rs1;
    iq_src_t             rs2;
  } iq_entry_t;

endpackage

// File: rtl/mult_issue_queue_iq_src_capture.sv
// One source operand's CDB snoop: a pending operand whose producer tag matches the broadcast takes the result.
module iq_src_capture
  import mult_issue_queue_pkg::*;
(
  input  logic    en,
  input  iq_src_t src,
  input  cdb_bfm  cdb,
  output iq_src_t src_out
);

  logic hit;
  assign hit = en & ~src.valid & cdb.valid & (src.tag == cdb.tag);

  always_comb begin
    src_out = src;
    if (hit) begin
      src_out.valid = 1'b1;
      src_out.data  = cdb.result;
    end
  end

endmodule

// File: rtl/mult_issue_queue.sv
// Collapsing issue queue for MUL ops: waits for operands via CDB snoop, presents the oldest ready entry.
module mult_issue_queue
  import mult_issue_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = IQ_TAG_W,
  parameter int DATA_W = IQ_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              dispatch_en,
  input  logic [TAG_W-1:0]  dispatch_rd_tag,
  input  logic [DATA_W-1:0] dispatch_rs1_data,
  input  logic [TAG_W-1:0]  dispatch_rs1_tag,
  input  logic              dispatch_rs1_valid,
  input  logic [DATA_W-1:0] dispatch_rs2_data,
  input  logic [TAG_W-1:0]  dispatch_rs2_tag,
  input  logic              dispatch_rs2_valid,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_result,
  input  logic              issue_grant,
  output logic              queue_full,
  output logic              issue_queue_rdy,
  output common_fifo_data   mult_exec_fifo_data
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(DEPTH);

  iq_entry_t        entry_reg   [DEPTH];
  iq_entry_t        entry_next  [DEPTH];
  iq_entry_t        snoop_entry [DEPTH];
  iq_entry_t        shift_entry [DEPTH];
  iq_src_t          rs1_snoop   [DEPTH];
  iq_src_t          rs2_snoop   [DEPTH];
  logic [CW-1:0]    count_reg, count_next, count_after;
  logic [DEPTH-1:0] ready;
  logic [SW-1:0]    sel;
  logic             issue_fire, dispatch_fire;
  cdb_bfm           cdb;
  iq_src_t          disp_rs1_raw, disp_rs2_raw, disp_rs1_cap, disp_rs2_cap;
  iq_entry_t        disp_entry;

  assign cdb           = {cdb_valid, cdb_tag, cdb_result};
  assign queue_full    = (count_reg == CW'(DEPTH));
  assign issue_fire    = issue_queue_rdy & issue_grant;
  assign dispatch_fire = dispatch_en & ~queue_full;
  assign count_after   = count_reg - CW'(issue_fire);
  assign count_next    = count_after + CW'(dispatch_fire);

  // Incoming op snoops the same-cycle broadcast so it is not left waiting on a result already gone by.
  assign disp_rs1_raw = {dispatch_rs1_data, dispatch_rs1_tag, dispatch_rs1_valid};
  assign disp_rs2_raw = {dispatch_rs2_data, dispatch_rs2_tag, dispatch_rs2_valid};
  iq_src_capture u_disp_rs1 (.en(1'b1), .src(disp_rs1_raw), .cdb(cdb), .src_out(disp_rs1_cap));
  iq_src_capture u_disp_rs2 (.en(1'b1), .src(disp_rs2_raw), .cdb(cdb), .src_out(disp_rs2_cap));
  assign disp_entry = {1'b1, dispatch_rd_tag, disp_rs1_cap, disp_rs2_cap};

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign ready[gi] = entry_reg[gi].valid & entry_reg[gi].rs1.valid & entry_reg[gi].rs2.valid;

      iq_src_capture u_rs1 (.en(entry_reg[gi].valid), .src(entry_reg[gi].rs1), .cdb(cdb), .src_out(rs1_snoop[gi]));
      iq_src_capture u_rs2 (.en(entry_reg[gi].valid), .src(entry_reg[gi].rs2), .cdb(cdb), .src_out(rs2_snoop[gi]));
      assign snoop_entry[gi] = {entry_reg[gi].valid, entry_reg[gi].rd_tag, rs1_snoop[gi], rs2_snoop[gi]};

      // Slots at or above the issued index pull from the next-younger slot, snoop results included.
      if (gi == DEPTH - 1) begin : g_top
        assign shift_entry[gi] = (issue_fire && sel <= SW'(gi)) ? '0 : snoop_entry[gi];
      end else begin : g_mid
        assign shift_entry[gi] = (issue_fire && sel <= SW'(gi)) ? snoop_entry[gi+1] : snoop_entry[gi];
      end

      assign entry_next[gi] = (dispatch_fire && count_after == CW'(gi)) ? disp_entry : shift_entry[gi];
    end
  endgenerate

  always_comb begin
    sel             = '0;
    issue_queue_rdy = |ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready[i]) sel = SW'(i);
    end
  end

  always_comb begin
    mult_exec_fifo_data = '0;
    if (issue_queue_rdy) begin
      mult_exec_fifo_data.rd_tag   = entry_reg[sel].rd_tag;
      mult_exec_fifo_data.rs1_data = entry_reg[sel].rs1.data;
      mult_exec_fifo_data.rs2_data = entry_reg[sel].rs2.data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
      for (int i = 0; i < DEPTH; i++) entry_reg[i] <= '0;
    end else if (flush) begin
      count_reg <= '0;
      for (int i = 0; i < DEPTH; i++) entry_reg[i] <= '0;
    end else begin
      count_reg <= count_next;
      for (int i = 0; i < DEPTH; i++) entry_reg[i] <= entry_next[i];
    end
  end

endmodule

// File: tb/tb_mult_issue_queue.sv
// Directed and random bench for mult_issue_queue, checked against a queue-based model of the entry list.
module tb_mult_issue_queue;
  import mult_issue_queue_pkg::*;

  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            dispatch_en = 1'b0;
  logic [5:0]      dispatch_rd_tag = '0;
  logic [31:0]     dispatch_rs1_data = '0;
  logic [5:0]      dispatch_rs1_tag = '0;
  logic            dispatch_rs1_valid = 1'b0;
  logic [31:0]     dispatch_rs2_data = '0;
  logic [5:0]      dispatch_rs2_tag = '0;
  logic            dispatch_rs2_valid = 1'b0;
  logic            cdb_valid = 1'b0;
  logic [5:0]      cdb_tag = '0;
  logic [31:0]     cdb_result = '0;
  logic            issue_grant = 1'b0;
  logic            queue_full;
  logic            issue_queue_rdy;
  common_fifo_data mult_exec_fifo_data;

  int vec_cnt = 0;
  int err_cnt = 0;

  mult_issue_queue #(.DEPTH(DEPTH), .TAG_W(6), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .dispatch_en(dispatch_en), .dispatch_rd_tag(dispatch_rd_tag),
    .dispatch_rs1_data(dispatch_rs1_data), .dispatch_rs1_tag(dispatch_rs1_tag), .dispatch_rs1_valid(dispatch_rs1_valid),
    .dispatch_rs2_data(dispatch_rs2_data), .dispatch_rs2_tag(dispatch_rs2_tag), .dispatch_rs2_valid(dispatch_rs2_valid),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_result(cdb_result),
    .issue_grant(issue_grant), .queue_full(queue_full), .issue_queue_rdy(issue_queue_rdy),
    .mult_exec_fifo_data(mult_exec_fifo_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  rd;
    logic        v1;
    logic [31:0] d1;
    logic [5:0]  t1;
    logic        v2;
    logic [31:0] d2;
    logic [5:0]  t2;
  } m_ent_t;

  m_ent_t q[$];

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  function automatic int find_ready();
    for (int i = 0; i < q.size(); i++)
      if (q[i].v1 && q[i].v2) return i;
    return -1;
  endfunction

  task automatic check_outputs(input string tag);
    int r;
    logic [69:0] exp_data;
    r = find_ready();
    exp_data = '0;
    if (r >= 0) exp_data = {q[r].rd, q[r].d1, q[r].d2};
    check_val({tag, ".full"}, 128'(queue_full), 128'(q.size() == DEPTH));
    check_val({tag, ".rdy"},  128'(issue_queue_rdy), 128'(r >= 0));
    check_val({tag, ".data"}, 128'(mult_exec_fifo_data), 128'(exp_data));
  endtask

  // Drives one cycle of inputs (called just after a falling edge), advances the model, checks the result.
  task automatic step(input string tag, input bit fl, input bit de, input logic [5:0] rd,
                      input logic [31:0] d1, input logic [5:0] t1, input bit v1,
                      input logic [31:0] d2, input logic [5:0] t2, input bit v2,
                      input bit cv, input logic [5:0] ct, input logic [31:0] cr, input bit g);
    int r;
    bit full_before;
    m_ent_t e;
    flush = fl; dispatch_en = de; dispatch_rd_tag = rd;
    dispatch_rs1_data = d1; dispatch_rs1_tag = t1; dispatch_rs1_valid = v1;
    dispatch_rs2_data = d2; dispatch_rs2_tag = t2; dispatch_rs2_valid = v2;
    cdb_valid = cv; cdb_tag = ct; cdb_result = cr; issue_grant = g;
    if (fl) begin
      q.delete();
    end else begin
      r = find_ready();
      full_before = (q.size() == DEPTH);
      for (int i = 0; i < q.size(); i++) begin
        if (cv && !q[i].v1 && q[i].t1 == ct) begin q[i].v1 = 1'b1; q[i].d1 = cr; end
        if (cv && !q[i].v2 && q[i].t2 == ct) begin q[i].v2 = 1'b1; q[i].d2 = cr; end
      end
      if (g && r >= 0) q.delete(r);
      if (de && !full_before) begin
        e = '{rd: rd, v1: v1, d1: d1, t1: t1, v2: v2, d2: d2, t2: t2};
        if (cv && !e.v1 && e.t1 == ct) begin e.v1 = 1'b1; e.d1 = cr; end
        if (cv && !e.v2 && e.t2 == ct) begin e.v2 = 1'b1; e.d2 = cr; end
        q.push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic idle(input string tag, input bit g);
    step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g);
  endtask

  task automatic disp(input string tag, input logic [5:0] rd, input logic [31:0] d1, input logic [5:0] t1,
                      input bit v1, input logic [31:0] d2, input logic [5:0] t2, input bit v2);
    step(tag, 0, 1, rd, d1, t1, v1, d2, t2, v2, 0, 0, 0, 0);
  endtask

  initial begin
    logic [69:0] held;
    // Reset
    @(negedge clk);
    check_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs("post_reset");

    // T1: ready-on-dispatch op, granted straight away
    step("t1_disp", 0, 1, 6'd5, 32'd3, 6'd0, 1, 32'd7, 6'd0, 1, 0, 0, 0, 1);
    check_val("t1_word", 128'(mult_exec_fifo_data), 128'({6'd5, 32'd3, 32'd7}));
    idle("t1_grant", 1);
    check_val("t1_empty", 128'(issue_queue_rdy), 128'(0));

    // T2: rs2 waits for tag 12, arriving two cycles after dispatch
    disp("t2_disp", 6'd9, 32'h11, 6'd0, 1, 32'h0, 6'd12, 0);
    idle("t2_wait", 0);
    step("t2_cdb", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6'd12, 32'h10, 0);
    check_val("t2_word", 128'(mult_exec_fifo_data), 128'({6'd9, 32'h11, 32'h10}));
    idle("t2_grant", 1);

    // T3: full queue, only the third entry ready, then a fifth dispatch after the grant
    disp("t3_e0", 6'd1, 32'h1, 6'd40, 0, 32'h2, 6'd0, 1);
    disp("t3_e1", 6'd2, 32'h3, 6'd41, 0, 32'h4, 6'd0, 1);
    disp("t3_e2", 6'd3, 32'h5, 6'd0, 1, 32'h6, 6'd0, 1);
    disp("t3_e3", 6'd4, 32'h7, 6'd0, 1, 32'h8, 6'd42, 0);
    check_val("t3_full", 128'(queue_full), 128'(1));
    check_val("t3_word", 128'(mult_exec_fifo_data), 128'({6'd3, 32'h5, 32'h6}));
    idle("t3_grant", 1);
    check_val("t3_notfull", 128'(queue_full), 128'(0));
    disp("t3_e4", 6'd6, 32'h9, 6'd0, 1, 32'hA, 6'd0, 1);
    step("t3_wake", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6'd42, 32'h77, 0);
    check_val("t3_e3_word", 128'(mult_exec_fifo_data), 128'({6'd4, 32'h7, 32'h77}));
    step("t3_flush", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // T4: dispatch bypass capture from the same-cycle CDB
    step("t4_disp", 0, 1, 6'd13, 32'h0, 6'd20, 0, 32'h5, 6'd0, 1, 1, 6'd20, 32'hAB, 0);
    check_val("t4_word", 128'(mult_exec_fifo_data), 128'({6'd13, 32'hAB, 32'h5}));
    idle("t4_grant", 1);

    // T5: stable presentation under backpressure
    disp("t5_e0", 6'd21, 32'h21, 6'd0, 1, 32'h22, 6'd0, 1);
    disp("t5_e1", 6'd22, 32'h31, 6'd0, 1, 32'h32, 6'd0, 1);
    held = mult_exec_fifo_data;
    for (int i = 0; i < 3; i++) begin
      idle("t5_hold", 0);
      check_val("t5_stable", 128'(mult_exec_fifo_data), 128'({6'd21, 32'h21, 32'h22}));
    end
    check_val("t5_held", 128'(held), 128'({6'd21, 32'h21, 32'h22}));
    idle("t5_grant", 1);
    check_val("t5_next", 128'(mult_exec_fifo_data), 128'({6'd22, 32'h31, 32'h32}));
    idle("t5_drain", 1);

    // T6: flush beats dispatch and snoop
    disp("t6_e0", 6'd1, 32'h1, 6'd0, 1, 32'h2, 6'd0, 1);
    disp("t6_e1", 6'd2, 32'h3, 6'd50, 0, 32'h4, 6'd0, 1);
    disp("t6_e2", 6'd3, 32'h5, 6'd0, 1, 32'h6, 6'd0, 1);
    step("t6_flush", 1, 1, 6'd7, 32'h8, 6'd0, 1, 32'h9, 6'd0, 1, 1, 6'd50, 32'h99, 0);
    check_val("t6_rdy", 128'(issue_queue_rdy), 128'(0));
    check_val("t6_word", 128'(mult_exec_fifo_data), 128'(0));

    // Random traffic with occasional async reset
    for (int n = 0; n < 3000; n++) begin
      bit de, g, fl, cv;
      de = ($urandom_range(0, 99) < 55) && (q.size() < DEPTH);
      g  = ($urandom_range(0, 99) < 60);
      fl = ($urandom_range(0, 99) < 2);
      cv = ($urandom_range(0, 99) < 50);
      if (n % 701 == 350) begin
        disp("pre_rst", 6'(n), 32'h1, 6'd0, 1, 32'h2, 6'd0, 1);
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        check_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
      end
      step("rnd", fl, de, 6'($urandom_range(0, 63)), $urandom, 6'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
           $urandom, 6'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
           cv, 6'($urandom_range(0, 7)), $urandom, g);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
